// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl: streams X then Y into the engine's memories, starts the engine,
// and streams the Z memory back out with a last marker.
module matmul_stream_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int N          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  x_wr_en,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic                  y_wr_en,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic [ADDR_WIDTH-1:0] z_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    typedef enum logic [2:0] {LOAD_X, LOAD_Y, START, WAIT, RD_ADDR, RD_DATA, OUT} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N * N - 1);
    state_t state, next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic waited, accept, at_last;
    assign in_ready = state == LOAD_X || state == LOAD_Y;
    assign accept   = in_valid && in_ready;
    assign at_last  = cnt == LAST;
    assign x_wr_en  = accept && state == LOAD_X;
    assign y_wr_en  = accept && state == LOAD_Y;
    assign x_addr   = cnt;
    assign y_addr   = cnt;
    assign x_din    = in_data;
    assign y_din    = in_data;
    assign mm_start = state == START;
    assign z_addr   = (state == RD_ADDR || state == RD_DATA || state == OUT) ? cnt : '0;
    always_comb begin
        next = state;
        case (state)
            LOAD_X:  next = accept && at_last ? LOAD_Y : LOAD_X;
            LOAD_Y:  next = accept && at_last ? START : LOAD_Y;
            START:   next = WAIT;
            WAIT:    next = waited && mm_done ? RD_ADDR : WAIT;
            RD_ADDR: next = RD_DATA;
            RD_DATA: next = OUT;
            OUT:     next = out_ready ? (out_last ? LOAD_X : RD_ADDR) : OUT;
            default: next = LOAD_X;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= LOAD_X;
        else       state <= next;
    // waited masks a done level left over from the previous job during the first WAIT cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            waited    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                LOAD_X, LOAD_Y: if (accept) cnt <= at_last ? '0 : cnt + 1'b1;
                START: waited <= 1'b0;
                WAIT: begin
                    waited <= 1'b1;
                    if (waited && mm_done) cnt <= '0;
                end
                RD_DATA: begin
                    out_data  <= z_dout;
                    out_valid <= 1'b1;
                    out_last  <= at_last;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    cnt       <= out_last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// tb_matmul_stream_ctrl: directed jobs against behavioural X/Y/Z memories and a
// latency-modelled engine that holds done high between jobs.
module tb_matmul_stream_ctrl;
    localparam int DW = 32, AW = 6, N = 8, NN = N * N, ENG_LAT = 4;
    logic clock = 0, reset = 1;
    logic in_valid = 0, in_ready, x_wr_en, y_wr_en, mm_start, mm_done;
    logic [DW-1:0] in_data = 0, x_din, y_din, z_dout, out_data;
    logic [AW-1:0] x_addr, y_addr, z_addr;
    logic out_valid, out_ready = 0, out_last;
    logic [DW-1:0] xmem [NN], ymem [NN], zmem [NN];
    int n_chk = 0, n_fail = 0, n_start = 0, n_wr = 0, cyc = 0, st_cyc = 0, lat_meas = 0;
    bit got_first = 0;

    matmul_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(N)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .x_wr_en(x_wr_en), .x_addr(x_addr), .x_din(x_din),
        .y_wr_en(y_wr_en), .y_addr(y_addr), .y_din(y_din),
        .mm_start(mm_start), .mm_done(mm_done), .z_addr(z_addr), .z_dout(z_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (x_wr_en) begin xmem[x_addr] <= x_din; n_wr++; end
        if (y_wr_en) begin ymem[y_addr] <= y_din; n_wr++; end
        z_dout <= zmem[z_addr];
    end

    always @(negedge clock) begin
        cyc++;
        if (mm_start) begin n_start++; st_cyc = cyc; got_first = 0; end
        if (out_valid && !got_first) begin lat_meas = cyc - st_cyc; got_first = 1; end
    end

    // Engine: done keeps its old level for one cycle after start, drops, then rises after ENG_LAT
    initial begin
        mm_done = 0;
        for (int i = 0; i < NN; i++) zmem[i] = 0;
        forever begin
            @(posedge clock);
            if (mm_start === 1'b1) begin
                @(posedge clock);
                mm_done <= 0;
                repeat (ENG_LAT) @(posedge clock);
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        logic [DW-1:0] s;
                        s = 0;
                        for (int k = 0; k < N; k++) s += xmem[r*N+k] * ymem[k*N+c];
                        zmem[r*N+c] = s;
                    end
                mm_done <= 1;
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] xv(input int xk, input int a);
        return xk == 0 ? DW'((a / N) == (a % N)) : 32'd2;
    endfunction

    function automatic logic [DW-1:0] yv(input int yk, input int off, input int a);
        return yk == 0 ? DW'(a + off) : (yk == 1 ? 32'd1 : 32'hFFFFFFFB);
    endfunction

    task automatic load(input int xk, input int yk, input int off, input bit gaps, input int nwords);
        int i = 0, guard = 0;
        bit acc;
        while (i < nwords && guard < 4000) begin
            @(negedge clock);
            if (gaps && $urandom_range(1) == 0) in_valid = 0;
            else begin
                in_valid = 1;
                in_data = i < NN ? xv(xk, i) : yv(yk, off, i - NN);
            end
            acc = in_valid && in_ready;
            @(posedge clock);
            if (acc) i++;
            guard++;
        end
        if (i < nwords) check("load_timeout", DW'(i), DW'(nwords));
        #1 in_valid = 0;
    endtask

    task automatic run_job(input int xk, input int yk, input int off, input bit gaps, input int rdy_pct);
        int s0, w0, k = 0, guard = 0, stab = 0;
        bit hold = 0, last_seen = 0;
        logic [DW-1:0] hd;
        logic hl;
        s0 = n_start;
        w0 = n_wr;
        load(xk, yk, off, gaps, 2 * NN);
        check("no_early_start", DW'(n_start - s0), 0);
        @(negedge clock);
        check("start_after_last_y", DW'(mm_start), 1);
        check("in_ready_start", DW'(in_ready), 0);
        in_valid = 1;
        in_data = 32'hDEAD_BEEF;
        while (k < NN && guard < 4000) begin
            @(negedge clock);
            if (hold && (!out_valid || out_data !== hd || out_last !== hl)) stab++;
            out_ready = $urandom_range(99) < rdy_pct;
            if (out_valid && out_ready) begin
                check($sformatf("z[%0d]", k), out_data, xk == 1 ? 32'd16 : yv(yk, off, k));
                check($sformatf("last[%0d]", k), DW'(out_last), DW'(k == NN - 1));
                k++;
            end
            hold = out_valid && !out_ready;
            hd = out_data;
            hl = out_last;
            @(posedge clock);
            guard++;
        end
        if (k < NN) check("out_timeout", DW'(k), NN);
        @(negedge clock);
        out_ready = 0;
        in_valid = 0;
        check("in_ready_after_last", DW'(in_ready), 1);
        check("start_pulses", DW'(n_start - s0), 1);
        check("write_count", DW'(n_wr - w0), 2 * NN);
        check("done_to_valid_latency", DW'(lat_meas), DW'(ENG_LAT + 5));
        check("hold_stable", DW'(stab), 0);
    endtask

    initial begin
        int s0;
        #12;
        check("rst_out_valid", DW'(out_valid), 0);
        check("rst_mm_start", DW'(mm_start), 0);
        check("rst_out_data", out_data, 0);
        check("rst_z_addr", DW'(z_addr), 0);
        @(negedge clock) reset = 0;
        @(negedge clock);
        check("in_ready_after_rst", DW'(in_ready), 1);
        run_job(0, 0, 0, 0, 100);
        run_job(1, 1, 0, 0, 100);
        run_job(0, 2, 0, 0, 100);
        run_job(0, 0, 0, 1, 30);
        s0 = n_start;
        load(0, 0, 0, 0, NN + 20);
        @(negedge clock);
        check("ly_wr_mid", DW'(y_wr_en), 0);
        reset = 1;
        #1;
        check("abort_out_valid", DW'(out_valid), 0);
        check("abort_mm_start", DW'(mm_start), 0);
        check("abort_y_wr", DW'(y_wr_en), 0);
        @(negedge clock) reset = 0;
        @(negedge clock);
        check("abort_in_ready", DW'(in_ready), 1);
        check("abort_no_start", DW'(n_start - s0), 0);
        run_job(0, 0, 0, 0, 100);
        for (int j = 1; j <= 3; j++) run_job(0, 0, 100 * j, 0, 100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_stream_ctrl.md
# matmul_stream_ctrl

Host-side streaming front end for the matmul engine. It accepts a word stream over valid/ready, writes matrix X and then matrix Y into the engine's X/Y memories, pulses the engine's start, and waits for done. It then reads the Z memory out and emits it as a valid/ready stream with a last marker. Relative to the engine, it writes the memories the engine reads and reads the memory the engine writes.

## Interface
- DATA_WIDTH, 32, word width of all memories and streams.
- ADDR_WIDTH, 6, memory address width; N*N <= 2**ADDR_WIDTH required.
- N, 8, matrix dimension; matrices are row-major, element (r,c) at address r*N+c.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input stream word valid
- in_ready  out  1  block can accept an input word
- in_data  in  DATA_WIDTH  input word (X elements first, then Y elements, each in row-major order)
- x_wr_en / y_wr_en  out  1  write strobe to X / Y memory
- x_addr / y_addr  out  ADDR_WIDTH  write address
- x_din / y_din  out  DATA_WIDTH  write data
- mm_start  out  1  one-cycle start pulse to the engine
- mm_done  in  1  engine completion (pulse or level)
- z_addr  out  ADDR_WIDTH  Z memory read address
- z_dout  in  DATA_WIDTH  Z read data, valid one cycle after z_addr (synchronous BRAM)
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts output word
- out_data  out  DATA_WIDTH  output word (registered)
- out_last  out  1  marks the final Z element (address N*N-1)

## Operation
- Internal counter cnt has ADDR_WIDTH bits and counts 0..N*N-1. States: LOAD_X, LOAD_Y, START, WAIT, RD_ADDR, RD_DATA, OUT.
- LOAD_X:
  - in_ready=1.
  - A word is accepted when in_valid&&in_ready. In that cycle: x_wr_en=1, x_addr=cnt, x_din=in_data (all combinational).
  - cnt increments per accepted word.
  - Acceptance at cnt==N*N-1 sets cnt to 0 and moves to LOAD_Y.
- LOAD_Y: identical to LOAD_X but on the y_* port. The last accepted word moves to START.
- START: mm_start=1 for exactly this one cycle; in_ready=0; next state is WAIT.
- WAIT:
  - mm_done is ignored in the first WAIT cycle, which masks a stale level from the previous job.
  - From the second cycle on, mm_done=1 sets cnt to 0 and moves to RD_ADDR.
- RD_ADDR: z_addr=cnt; next state is RD_DATA.
- RD_DATA:
  - z_addr=cnt is held.
  - At the clock edge, out_data<=z_dout, out_valid<=1, out_last<=(cnt==N*N-1); next state is OUT.
- OUT:
  - out_valid, out_data and out_last are held stable until out_ready=1.
  - On acceptance, out_valid<=0 and out_last<=0.
  - If last: cnt<=0 and return to LOAD_X.
  - Otherwise: cnt++ and go to RD_ADDR.
- Default values outside the named states:
  - in_ready=0 in every state except LOAD_X/LOAD_Y.
  - All write strobes are 0.
  - z_addr=0 outside RD_ADDR/RD_DATA/OUT; in OUT, z_addr=cnt.
- Data is passed through unmodified; there is no arithmetic on data. Only cnt arithmetic exists; cnt never wraps because the terminal compare at N*N-1 always precedes any wrap.

## Timing
- Reset (asynchronous, any state): state=LOAD_X, cnt=0, out_valid=0, out_last=0, out_data=0, mm_start=0, all write strobes=0, z_addr=0. in_ready=1 from the first cycle after reset is released.
- A reset during any phase aborts the job. Partially written memory contents are not cleared; the next job overwrites them.
- Load throughput: 1 word/cycle with in_valid held high. Minimum load time is 2*N*N cycles.
- mm_start is asserted 1 cycle after the last Y word is accepted.
- First out_valid rises 3 cycles after the first qualifying mm_done cycle (RD_ADDR, RD_DATA, then OUT).
- Readout throughput is 1 word per 3 cycles with out_ready held high; each extra out_ready-low cycle adds 1 cycle.
- in_valid while in_ready=0 is ignored; the word is not consumed.
- out_ready while out_valid=0 has no effect.
- mm_done arriving during LOAD_*, START, or the first WAIT cycle has no effect.

## Test plan
- Load identity X and Y[a]=a for a=0..63 (N=8) against the matmul engine, out_ready=1 -> 64 outputs with values 0..63 in order, out_last only on value 63, and exactly one mm_start pulse.
- Load X all 2 and Y all 1 -> all 64 outputs equal 16. Load X identity and Y all -5 -> all outputs equal 0xFFFFFFFB.
- Random in_valid gaps (50%) and random out_ready (30% high) -> identical output sequence, with out_data/out_last stable while out_valid&&!out_ready.
- Assert reset during LOAD_Y at cnt=20, then run the full identity job -> correct 0..63 output, and no mm_start pulse before the new Y load completes.
- Hold mm_done high (stub engine) from the previous job, then run a new load -> the block spends at least 2 cycles in WAIT and does not read Z before the stub re-asserts done.
- Three back-to-back jobs with different Y ramps -> each job's out_last is followed by in_ready=1 in the next cycle, and all results are correct.
